// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: FSM states, command
// frame field positions, R/W encodings and the read-timeout fill word.
package spi_reg_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitWdata = 2'd1,
    StWaitRdata = 2'd2
  } state_e;

  localparam int unsigned FrameW     = 16;
  localparam int unsigned AddrW      = 7;

  // Command frame layout: [15] R/W, [14:8] address, [7:1] reserved, [0] parity
  localparam int unsigned CmdRwBit   = 15;
  localparam int unsigned CmdAddrMsb = 14;
  localparam int unsigned CmdAddrLsb = 8;
  localparam int unsigned CmdParBit  = 0;

  localparam logic CmdRead  = 1'b1;
  localparam logic CmdWrite = 1'b0;

  // Returned to the master when the register file never answers a read
  localparam logic [FrameW-1:0] TimeoutData = 16'hDEAD;

  function automatic logic [AddrW-1:0] cmd_addr(input logic [FrameW-1:0] frame);
    return frame[CmdAddrMsb:CmdAddrLsb];
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Bus bundle between the SPI frame engine / register file and the bridge.
// slave: the bridge itself; master: the surrounding SPI core and register file.
interface spi_reg_bridge_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  // SPI frame side
  logic                 rx_data_ready;
  logic [15:0]          rx_data;
  logic                 spi_clk_error;
  logic                 tx_data_ready;
  logic [15:0]          tx_data;
  // Register file side
  logic [6:0]           reg_addr;
  logic                 reg_wr_en;
  logic [15:0]          reg_wdata;
  logic                 reg_rd_en;
  logic [15:0]          reg_rdata;
  logic                 reg_rd_valid;
  // Status
  logic                 cmd_error;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  rx_data_ready, rx_data, spi_clk_error, reg_rdata, reg_rd_valid,
    output tx_data_ready, tx_data, reg_addr, reg_wr_en, reg_wdata, reg_rd_en,
           cmd_error, err_cnt
  );

  modport master (
    output rx_data_ready, rx_data, spi_clk_error, reg_rdata, reg_rd_valid,
    input  tx_data_ready, tx_data, reg_addr, reg_wr_en, reg_wdata, reg_rd_en,
           cmd_error, err_cnt
  );

endinterface

// File: rtl/spi_reg_bridge_timer.sv
// Read-timeout down-counter. load_i arms it; while count_i is high it counts
// down, and expire_o is high during the Cycles-th counting cycle after load.
module spi_reg_bridge_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned    CntW    = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: reload on arm, otherwise step down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is a single-cycle strobe on the last counting cycle
  always_comb begin
    expire_o = count_i && !load_i && (cnt_q == '0);
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI command-frame to register-bus bridge.
// Build option: define SPI_REG_BRIDGE_PARITY_EN to require even parity over
// every command frame; failing frames are dropped and flagged on cmd_error.
// spi_clk_error only aborts the transaction; it is not counted as cmd_error.
// A read timeout also pulses tx_data_ready so the master shifts out 16'hDEAD.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 16,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_reg_bridge_if.slave bus_io
);

  state_e               state_q;
  logic                 tx_data_ready_q;
  logic [15:0]          tx_data_q;
  logic [AddrW-1:0]     reg_addr_q;
  logic                 reg_wr_en_q;
  logic [15:0]          reg_wdata_q;
  logic                 reg_rd_en_q;
  logic                 cmd_error_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic rx_fire;
  logic parity_ok;
  logic rd_cmd_go;
  logic in_rdata;
  logic rd_expire;
  logic err_event;

`ifdef SPI_REG_BRIDGE_PARITY_EN
  // Even parity: XOR of all sixteen bits must be zero
  always_comb begin
    parity_ok = ~(^bus_io.rx_data);
  end
`else
  always_comb begin
    parity_ok = 1'b1;
  end
`endif

  // Frame qualification and error detection; clock errors win over frames
  always_comb begin
    rx_fire   = bus_io.rx_data_ready && !bus_io.spi_clk_error;
    in_rdata  = (state_q == StWaitRdata);
    rd_cmd_go = (state_q == StIdle) && rx_fire && parity_ok &&
                (bus_io.rx_data[CmdRwBit] == CmdRead);
    err_event = !bus_io.spi_clk_error &&
                (((state_q == StIdle) && bus_io.rx_data_ready && !parity_ok) ||
                 (in_rdata && bus_io.rx_data_ready) ||
                 (in_rdata && rd_expire && !bus_io.reg_rd_valid));
  end

  spi_reg_bridge_timer #(
    .Cycles (RD_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (rd_cmd_go),
    .count_i  (in_rdata),
    .expire_o (rd_expire)
  );

  // Main FSM with all outputs registered; strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      tx_data_ready_q <= 1'b0;
      tx_data_q       <= '0;
      reg_addr_q      <= '0;
      reg_wr_en_q     <= 1'b0;
      reg_wdata_q     <= '0;
      reg_rd_en_q     <= 1'b0;
      cmd_error_q     <= 1'b0;
      err_cnt_q       <= '0;
    end else begin
      tx_data_ready_q <= 1'b0;
      reg_wr_en_q     <= 1'b0;
      reg_rd_en_q     <= 1'b0;
      cmd_error_q     <= err_event;
      if (err_event && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (rx_fire && parity_ok) begin
            reg_addr_q <= cmd_addr(bus_io.rx_data);
            if (bus_io.rx_data[CmdRwBit] == CmdRead) begin
              reg_rd_en_q <= 1'b1;
              state_q     <= StWaitRdata;
            end else begin
              state_q     <= StWaitWdata;
            end
          end
        end
        StWaitWdata: begin
          if (bus_io.spi_clk_error) begin
            state_q <= StIdle;
          end else if (bus_io.rx_data_ready) begin
            reg_wdata_q <= bus_io.rx_data;
            reg_wr_en_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StWaitRdata: begin
          // Frames arriving here are dropped; only the error path sees them
          if (bus_io.spi_clk_error) begin
            state_q <= StIdle;
          end else if (bus_io.reg_rd_valid) begin
            tx_data_q       <= bus_io.reg_rdata;
            tx_data_ready_q <= 1'b1;
            state_q         <= StIdle;
          end else if (rd_expire) begin
            tx_data_q       <= TimeoutData;
            tx_data_ready_q <= 1'b1;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.tx_data_ready = tx_data_ready_q;
  assign bus_io.tx_data       = tx_data_q;
  assign bus_io.reg_addr      = reg_addr_q;
  assign bus_io.reg_wr_en     = reg_wr_en_q;
  assign bus_io.reg_wdata     = reg_wdata_q;
  assign bus_io.reg_rd_en     = reg_rd_en_q;
  assign bus_io.cmd_error     = cmd_error_q;
  assign bus_io.err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed scenarios with literal expectations plus a
// transaction-level reference model compared against every output each cycle.
module tb_spi_reg_bridge;

  localparam int unsigned RdTimeout = 16;
  localparam int unsigned ErrCntW   = 8;

`ifdef SPI_REG_BRIDGE_PARITY_EN
  localparam logic [15:0] RdCmd  = 16'h8A01;
  localparam logic [15:0] Frame4 = 16'h1235;
`else
  localparam logic [15:0] RdCmd  = 16'h8A00;
  localparam logic [15:0] Frame4 = 16'h1234;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_bridge_if #(.ERR_CNT_W(ErrCntW)) bus ();

  spi_reg_bridge #(
    .RD_TIMEOUT (RdTimeout),
    .ERR_CNT_W  (ErrCntW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 waiting for a command, 1 waiting for write data, 2 read pending
  int          m_phase  = 0;
  int          m_waited = 0;
  int          e_cnt    = 0;
  logic        m_err    = 1'b0;
  logic        e_txr    = 1'b0;
  logic [15:0] e_tx     = '0;
  logic [6:0]  e_addr   = '0;
  logic        e_wr     = 1'b0;
  logic [15:0] e_wdata  = '0;
  logic        e_rd     = 1'b0;
  logic        e_err    = 1'b0;

  function automatic logic parity_bad(input logic [15:0] f);
`ifdef SPI_REG_BRIDGE_PARITY_EN
    return ^f;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_waited = 0; e_cnt = 0;
        e_txr = 0; e_tx = '0; e_addr = '0; e_wr = 0; e_wdata = '0; e_rd = 0; e_err = 0;
      end else begin
        m_err = 1'b0;
        e_txr = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        if (bus.spi_clk_error) begin
          m_phase = 0;
        end else if (m_phase == 0) begin
          if (bus.rx_data_ready) begin
            if (parity_bad(bus.rx_data)) begin
              m_err = 1'b1;
            end else begin
              e_addr = bus.rx_data[14:8];
              if (bus.rx_data[15]) begin
                e_rd = 1'b1; m_phase = 2; m_waited = 0;
              end else begin
                m_phase = 1;
              end
            end
          end
        end else if (m_phase == 1) begin
          if (bus.rx_data_ready) begin
            e_wdata = bus.rx_data; e_wr = 1'b1; m_phase = 0;
          end
        end else begin
          m_waited++;
          if (bus.rx_data_ready) m_err = 1'b1;
          if (bus.reg_rd_valid) begin
            e_tx = bus.reg_rdata; e_txr = 1'b1; m_phase = 0;
          end else if (m_waited == RdTimeout) begin
            e_tx = 16'hDEAD; e_txr = 1'b1; m_err = 1'b1; m_phase = 0;
          end
        end
        e_err = m_err;
        if (m_err && e_cnt < (2 ** ErrCntW) - 1) e_cnt++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_tx_data_ready", 32'(bus.tx_data_ready), 32'(e_txr));
        check("cyc_tx_data",       32'(bus.tx_data),       32'(e_tx));
        check("cyc_reg_addr",      32'(bus.reg_addr),      32'(e_addr));
        check("cyc_reg_wr_en",     32'(bus.reg_wr_en),     32'(e_wr));
        check("cyc_reg_wdata",     32'(bus.reg_wdata),     32'(e_wdata));
        check("cyc_reg_rd_en",     32'(bus.reg_rd_en),     32'(e_rd));
        check("cyc_cmd_error",     32'(bus.cmd_error),     32'(e_err));
        check("cyc_err_cnt",       32'(bus.err_cnt),       32'(e_cnt));
      end
    end
  end

  // ---------------- pulse counters ----------------
  int n_wr = 0, n_txr = 0, n_err = 0;
  always @(negedge clk) begin
    if (bus.reg_wr_en === 1'b1)     n_wr  <= n_wr + 1;
    if (bus.tx_data_ready === 1'b1) n_txr <= n_txr + 1;
    if (bus.cmd_error === 1'b1)     n_err <= n_err + 1;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f);
    bus.rx_data_ready = 1'b1;
    bus.rx_data       = f;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic rd_answer(input logic [15:0] d);
    bus.reg_rd_valid = 1'b1;
    bus.reg_rdata    = d;
    @(negedge clk);
    bus.reg_rd_valid = 1'b0;
  endtask

  task automatic clk_err_pulse();
    bus.spi_clk_error = 1'b1;
    @(negedge clk);
    bus.spi_clk_error = 1'b0;
  endtask

  int s_wr, s_txr, s_err;

  initial begin
    bus.rx_data_ready = 1'b0;
    bus.rx_data       = '0;
    bus.spi_clk_error = 1'b0;
    bus.reg_rdata     = '0;
    bus.reg_rd_valid  = 1'b0;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_err_cnt", 32'(bus.err_cnt), 32'h0);
    check("reset_reg_addr", 32'(bus.reg_addr), 32'h0);
    check("reset_tx_data", 32'(bus.tx_data), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Write 0x1234 to address 0x05
    s_wr = n_wr;
    send_frame(16'h0500);
    check("wr_addr_latched", 32'(bus.reg_addr), 32'h05);
    send_frame(16'h1234);
    check("wr_strobe", 32'(bus.reg_wr_en), 32'h1);
    check("wr_wdata", 32'(bus.reg_wdata), 32'h1234);
    check("wr_addr", 32'(bus.reg_addr), 32'h05);
    idle(2);
    check("wr_count", 32'(n_wr - s_wr), 32'h1);

    // Read of address 0x0A answered after 3 cycles
    s_txr = n_txr;
    send_frame(RdCmd);
    check("rd_strobe", 32'(bus.reg_rd_en), 32'h1);
    check("rd_addr", 32'(bus.reg_addr), 32'h0A);
    idle(2);
    rd_answer(16'hBEEF);
    check("rd_tx_ready", 32'(bus.tx_data_ready), 32'h1);
    check("rd_tx_data", 32'(bus.tx_data), 32'hBEEF);
    idle(2);
    check("rd_tx_count", 32'(n_txr - s_txr), 32'h1);

    // Read with no answer: timeout on the 16th waiting cycle
    send_frame(RdCmd);
    idle(15);
    check("to_not_early", 32'(bus.tx_data_ready), 32'h0);
    idle(1);
    check("to_tx_ready", 32'(bus.tx_data_ready), 32'h1);
    check("to_tx_data", 32'(bus.tx_data), 32'hDEAD);
    check("to_cmd_error", 32'(bus.cmd_error), 32'h1);
    check("to_err_cnt", 32'(bus.err_cnt), 32'h1);
    idle(2);

    // Write aborted by spi_clk_error; next frame is a new command
    s_wr = n_wr;
    send_frame(16'h0500);
    clk_err_pulse();
    send_frame(Frame4);
    check("abort_no_wr", 32'(bus.reg_wr_en), 32'h0);
    check("abort_new_addr", 32'(bus.reg_addr), 32'h12);
    send_frame(16'h00FF);
    check("abort_followup_wdata", 32'(bus.reg_wdata), 32'h00FF);
    idle(2);
    check("abort_wr_count", 32'(n_wr - s_wr), 32'h1);

    // Odd-parity command 0x0501
    s_err = n_err;
    send_frame(16'h0501);
`ifdef SPI_REG_BRIDGE_PARITY_EN
    check("par_cmd_error", 32'(bus.cmd_error), 32'h1);
    check("par_addr_kept", 32'(bus.reg_addr), 32'h12);
    idle(2);
    check("par_err_count", 32'(n_err - s_err), 32'h1);
`else
    check("par_no_error", 32'(bus.cmd_error), 32'h0);
    check("par_addr", 32'(bus.reg_addr), 32'h05);
    send_frame(16'hA5A5);
    check("par_wr_strobe", 32'(bus.reg_wr_en), 32'h1);
    check("par_wdata", 32'(bus.reg_wdata), 32'hA5A5);
    idle(2);
    check("par_err_count", 32'(n_err - s_err), 32'h0);
`endif

    // Reset in the middle of a write and of a read
    s_wr = n_wr;
    send_frame(16'h0500);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr", 32'(bus.reg_addr), 32'h0);
    check("async_rst_err_cnt", 32'(bus.err_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("rst_no_wr", 32'(n_wr - s_wr), 32'h0);
    send_frame(Frame4);
    check("rst_frame_is_cmd", 32'(bus.reg_addr), 32'h12);
    send_frame(16'h0000);
    s_txr = n_txr;
    s_err = n_err;
    send_frame(RdCmd);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(RdTimeout + 4);
    check("rst_rd_no_tx", 32'(n_txr - s_txr), 32'h0);
    check("rst_rd_no_err", 32'(n_err - s_err), 32'h0);

    // 300 dropped frames during pending reads; counter must saturate
    for (int it = 0; it < 60; it++) begin
      send_frame(RdCmd);
      for (int k = 0; k < 5; k++) begin
        send_frame(16'h0000);
        idle(1);
      end
      rd_answer(16'h0001);
      idle(1);
      if (it == 9) check("sat_err_cnt_50", 32'(bus.err_cnt), 32'd50);
    end
    check("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL provide parameter RD_TIMEOUT, default 16, meaning the maximum clk cycles to wait for reg_rd_valid.
REQ-002 SHALL provide parameter ERR_CNT_W, default 8, meaning the error counter width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data_ready  input  1  one-cycle pulse marking a received 16-bit frame.
REQ-006 SHALL have port rx_data  input  16  received frame, valid with rx_data_ready.
REQ-007 SHALL have port spi_clk_error  input  1  one-cycle pulse that aborts the current transaction.
REQ-008 SHALL have port tx_data_ready  output  1  one-cycle pulse that loads tx_data into the transmitter.
REQ-009 SHALL have port tx_data  output  16  response word, valid with tx_data_ready.
REQ-010 SHALL have port reg_addr  output  7  register address.
REQ-011 SHALL have port reg_wr_en  output  1  one-cycle write strobe.
REQ-012 SHALL have port reg_wdata  output  16  write data, valid with reg_wr_en.
REQ-013 SHALL have port reg_rd_en  output  1  one-cycle read strobe.
REQ-014 SHALL have port reg_rdata  input  16  read data, valid with reg_rd_valid.
REQ-015 SHALL have port reg_rd_valid  input  1  one-cycle pulse answering reg_rd_en.
REQ-016 SHALL have port cmd_error  output  1  one-cycle pulse on any protocol error.
REQ-017 SHALL have port err_cnt  output  ERR_CNT_W  count of errors, saturating.

Function
REQ-018 Command frame format SHALL be: bit15 = R/W (1 = read), bits14:8 = address, bits7:1 reserved (ignored), bit0 = parity.
REQ-019 FSM states SHALL be IDLE, WAIT_WDATA and WAIT_RDATA.
REQ-020 In IDLE, a write command frame SHALL latch reg_addr and move to WAIT_WDATA.
REQ-021 In WAIT_WDATA, the next frame SHALL become reg_wdata; reg_wr_en SHALL pulse the cycle after that rx_data_ready; the FSM then returns to IDLE.
REQ-022 In IDLE, a read command frame SHALL latch reg_addr, pulse reg_rd_en one cycle after rx_data_ready, and move to WAIT_RDATA.
REQ-023 In WAIT_RDATA, reg_rd_valid SHALL drive tx_data = reg_rdata with tx_data_ready pulsing the next cycle, then the FSM returns to IDLE; the master clocks the data out during its next frame.
REQ-024 If RD_TIMEOUT cycles elapse in WAIT_RDATA without reg_rd_valid, the block SHALL load tx_data = 16'hDEAD, pulse cmd_error, and return to IDLE.
REQ-025 An rx_data_ready pulse arriving while in WAIT_RDATA SHALL be dropped and SHALL pulse cmd_error; the FSM SHALL stay in WAIT_RDATA.
REQ-026 spi_clk_error SHALL force IDLE with no reg_wr_en, and SHALL take priority over a simultaneous rx_data_ready.
REQ-027 cmd_error SHALL increment err_cnt, which saturates at all-ones and never wraps.
REQ-028 A frame received in IDLE SHALL always be interpreted as a command, including the frame that clocks out read data.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: FSM IDLE; tx_data_ready, reg_wr_en, reg_rd_en and cmd_error low; tx_data, reg_addr and reg_wdata zero; err_cnt zero.
REQ-030 Reset mid-transaction SHALL discard the transaction with no pending strobe issued after release.

Configuration
REQ-031 Macro SPI_REG_BRIDGE_PARITY_EN SHALL control parity checking.
- Defined: the command frame requires even parity over bits15:0. On a mismatch the frame is dropped, cmd_error pulses, and the FSM stays in IDLE.
- Undefined: bit0 is ignored and no parity logic is synthesised.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the command field bit positions, the R/W encodings and the 16'hDEAD timeout value.
REQ-033 The read-timeout counter SHALL be a single sub-module, spi_reg_bridge_timer (load, count, expire pulse).

Verification
REQ-034 The bench SHALL cover: write cmd 16'h0500 then frame 16'h1234 -> one reg_wr_en with reg_addr = 7'h05 and reg_wdata = 16'h1234.
REQ-035 The bench SHALL cover: read cmd 16'h8A00, reg_rd_valid after 3 cycles with rdata 16'hBEEF -> tx_data = 16'hBEEF, one tx_data_ready.
REQ-036 The bench SHALL cover: read cmd with no reg_rd_valid -> after 16 cycles, tx_data = 16'hDEAD, cmd_error pulse, err_cnt = 1.
REQ-037 The bench SHALL cover: write cmd, then spi_clk_error, then frame 16'h1234 -> no reg_wr_en, and 16'h1234 is treated as a command.
REQ-038 The bench SHALL cover: with the macro defined, cmd 16'h0501 -> dropped, cmd_error pulse; with the macro undefined -> accepted as a write to address 7'h05.
REQ-039 The bench SHALL cover: 300 forced errors -> err_cnt holds at 8'hFF.
